jtsdram_bankchk: RTL and testbench

Parametrised SDRAM bank checker; successor to the single-bank, read-only, constant-pattern checker. Optionally fills an address window with a generated pattern, then reads it back, compares every word and reports error count and first failing address. Sits between the test sequencer and one bank port of the SDRAM controller, one instance per bank.

---
 rtl/jtsdram_pkg.sv | 28 ++
 rtl/jtsdram_pattern.sv | 62 ++++++
 rtl/jtsdram_bankchk.sv | 150 +++++++++++++++
 tb/tb_jtsdram_bankchk.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtsdram_pkg.sv
// Shared definitions for the SDRAM bank checker: pattern modes, FSM states, LFSR constants.
package jtsdram_pkg;

    typedef enum logic [1:0] {
        PAT_CONST = 2'd0,
        PAT_ADDR  = 2'd1,
        PAT_LFSR  = 2'd2,
        PAT_INV   = 2'd3
    } pat_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WREQ,
        ST_WWAIT,
        ST_RREQ,
        ST_RWAIT,
        ST_DONE
    } state_e;

    // Galois form of x^16+x^14+x^13+x^11+1, right-shifting
    localparam logic [15:0] LFSR_POLY    = 16'hB400;
    localparam logic [15:0] LFSR_SEED_NZ = 16'h0001;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/jtsdram_pattern.sv
// Pattern generator: owns the LFSR state and produces the DW-wide word for the
// address/mode it is given. Output reflects the post-reseed/advance state.
module jtsdram_pattern
    import jtsdram_pkg::*;
#(
    parameter int AW = 22,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          reseed,
    input  logic          advance,
    input  logic [1:0]    mode,
    input  logic [15:0]   seed,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] pattern
);

    localparam int unsigned LANES = DW / 16;

    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;

    always_comb begin
        lfsr_nxt = lfsr;
        if (reseed) begin
            lfsr_nxt = (seed == '0) ? LFSR_SEED_NZ : seed;
        end else if (advance) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                lfsr_nxt = lfsr_step(lfsr_nxt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED_NZ;
        end else begin
            lfsr <= lfsr_nxt;
        end
    end

    // Pattern is derived from lfsr_nxt so the caller can register it alongside the new address
    always_comb begin
        logic [15:0] a16;
        logic [15:0] s;
        pattern = '0;
        a16     = 16'(addr);
        s       = lfsr_nxt;
        for (int unsigned i = 0; i < LANES; i++) begin
            s = lfsr_step(s);
            case (pat_mode_e'(mode))
                PAT_CONST: pattern[i*16 +: 16] = seed;
                PAT_ADDR:  pattern[i*16 +: 16] = a16 + 16'(i);
                PAT_INV:   pattern[i*16 +: 16] = ~(a16 + 16'(i));
                PAT_LFSR:  pattern[i*16 +: 16] = s;
                default:   pattern[i*16 +: 16] = '0;
            endcase
        end
    end

endmodule

// File: rtl/jtsdram_bankchk.sv
// SDRAM bank checker: optional pattern fill of 0..addr_end, then read-back with
// mismatch counting and first-failing-address capture. All outputs registered.
module jtsdram_bankchk
    import jtsdram_pkg::*;
#(
    parameter int AW = 22,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          do_write,
    input  logic [1:0]    mode,
    input  logic [15:0]   seed,
    input  logic [AW-1:0] addr_end,
    output logic [AW-1:0] addr,
    output logic          rd,
    output logic          wr,
    output logic [DW-1:0] wr_data,
    input  logic          ack,
    input  logic          rdy,
    input  logic [DW-1:0] data_read,
    output logic          busy,
    output logic          done,
    output logic          bad,
    output logic [CW-1:0] err_cnt,
    output logic [AW-1:0] first_bad
);

    state_e        state, state_nxt;
    pat_mode_e     mode_q;
    logic [15:0]   seed_q;
    logic [AW-1:0] win_end;

    logic [AW-1:0] addr_nxt, first_bad_nxt;
    logic [CW-1:0] err_cnt_nxt;
    logic          bad_nxt;
    logic          reseed, advance;
    logic          wr_cmp, rd_cmp;
    logic [1:0]    mode_src;
    logic [15:0]   seed_src;
    logic [DW-1:0] pat;

    assign mode_src = start ? mode : mode_q;
    assign seed_src = start ? seed : seed_q;

    jtsdram_pattern #(
        .AW (AW),
        .DW (DW)
    ) u_pattern (
        .clk     (clk),
        .rst_n   (rst_n),
        .reseed  (reseed),
        .advance (advance),
        .mode    (mode_src),
        .seed    (seed_src),
        .addr    (addr_nxt),
        .pattern (pat)
    );

    // ack together with rdy completes the access without visiting the wait state
    assign wr_cmp = ((state == ST_WREQ) && ack && rdy) || ((state == ST_WWAIT) && rdy);
    assign rd_cmp = ((state == ST_RREQ) && ack && rdy) || ((state == ST_RWAIT) && rdy);

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        bad_nxt       = bad;
        err_cnt_nxt   = err_cnt;
        first_bad_nxt = first_bad;
        reseed        = 1'b0;
        advance       = 1'b0;
        if (start) begin
            addr_nxt      = '0;
            bad_nxt       = 1'b0;
            err_cnt_nxt   = '0;
            first_bad_nxt = '0;
            reseed        = 1'b1;
            state_nxt     = do_write ? ST_WREQ : ST_RREQ;
        end else begin
            case (state)
                ST_WREQ: if (ack) state_nxt = ST_WWAIT;
                ST_RREQ: if (ack) state_nxt = ST_RWAIT;
                default: ;
            endcase
            if (wr_cmp) begin
                if (addr == win_end) begin
                    addr_nxt  = '0;
                    reseed    = 1'b1;
                    state_nxt = ST_RREQ;
                end else begin
                    addr_nxt  = addr + AW'(1);
                    advance   = 1'b1;
                    state_nxt = ST_WREQ;
                end
            end
            if (rd_cmp) begin
                // wr_data still holds the expected word for the current address
                if (data_read != wr_data) begin
                    bad_nxt = 1'b1;
                    if (err_cnt != '1) err_cnt_nxt = err_cnt + CW'(1);
                    if (!bad) first_bad_nxt = addr;
                end
                if (addr == win_end) begin
                    state_nxt = ST_DONE;
                end else begin
                    addr_nxt  = addr + AW'(1);
                    advance   = 1'b1;
                    state_nxt = ST_RREQ;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mode_q    <= PAT_CONST;
            seed_q    <= '0;
            win_end   <= '0;
            addr      <= '0;
            rd        <= 1'b0;
            wr        <= 1'b0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bad       <= 1'b0;
            err_cnt   <= '0;
            first_bad <= '0;
        end else begin
            if (start) begin
                mode_q  <= pat_mode_e'(mode);
                seed_q  <= seed;
                win_end <= addr_end;
            end
            state     <= state_nxt;
            addr      <= addr_nxt;
            rd        <= (state_nxt == ST_RREQ);
            wr        <= (state_nxt == ST_WREQ);
            wr_data   <= pat;
            busy      <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
            done      <= (state_nxt == ST_DONE);
            bad       <= bad_nxt;
            err_cnt   <= err_cnt_nxt;
            first_bad <= first_bad_nxt;
        end
    end

endmodule

// File: tb/tb_jtsdram_bankchk.sv
// Bench for jtsdram_bankchk: memory responder with selectable latency and read
// corruption, a vector table of whole runs, and hand-written corner sequences.
module tb_jtsdram_bankchk;

    localparam int AW = 22;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          do_write = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [15:0]   seed = 16'd0;
    logic [AW-1:0] addr_end = '0;
    logic          ack = 1'b0;
    logic          rdy = 1'b0;
    logic [DW-1:0] data_read = '0;

    logic [AW-1:0] addr, first_bad;
    logic          rd, wr, busy, done, bad;
    logic [DW-1:0] wr_data;
    logic [CW-1:0] err_cnt;

    logic [AW-1:0] addr_s, first_bad_s;
    logic          rd_s, wr_s, busy_s, done_s, bad_s;
    logic [DW-1:0] wr_data_s;
    logic [1:0]    err_cnt_s;

    always #5 clk = ~clk;

    jtsdram_bankchk #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .do_write(do_write), .mode(mode),
        .seed(seed), .addr_end(addr_end), .addr(addr), .rd(rd), .wr(wr),
        .wr_data(wr_data), .ack(ack), .rdy(rdy), .data_read(data_read),
        .busy(busy), .done(done), .bad(bad), .err_cnt(err_cnt), .first_bad(first_bad)
    );

    // Narrow-counter twin sharing all inputs, used for saturation checks
    jtsdram_bankchk #(.AW(AW), .DW(DW), .CW(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .do_write(do_write), .mode(mode),
        .seed(seed), .addr_end(addr_end), .addr(addr_s), .rd(rd_s), .wr(wr_s),
        .wr_data(wr_data_s), .ack(ack), .rdy(rdy), .data_read(data_read),
        .busy(busy_s), .done(done_s), .bad(bad_s), .err_cnt(err_cnt_s), .first_bad(first_bad_s)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory responder
    logic [31:0]   mem [0:255];
    logic          fast = 1'b0;
    logic          pend = 1'b0;
    logic          waitc = 1'b0;
    logic          op_wr = 1'b0;
    logic [AW-1:0] op_addr = '0;
    logic [31:0]   op_data = '0;
    logic [15:0]   cmask = '0;
    int            nwr = 0;
    int            nrd = 0;

    task do_op;
        if (op_wr) begin
            mem[op_addr[7:0]] = op_data;
            nwr++;
        end else begin
            data_read = mem[op_addr[7:0]];
            if (op_addr < AW'(16) && cmask[op_addr[3:0]]) data_read = data_read ^ 32'h1;
            nrd++;
        end
    endtask

    always @(negedge clk) begin
        ack = 1'b0;
        rdy = 1'b0;
        if (!rst_n) begin
            pend  = 1'b0;
            waitc = 1'b0;
        end else if (pend) begin
            rdy  = 1'b1;
            pend = 1'b0;
            do_op();
        end else if (rd || wr) begin
            op_wr   = wr;
            op_addr = addr;
            op_data = wr_data;
            if (fast) begin
                ack = 1'b1;
                rdy = 1'b1;
                do_op();
            end else if (!waitc) begin
                waitc = 1'b1;
            end else begin
                ack   = 1'b1;
                pend  = 1'b1;
                waitc = 1'b0;
            end
        end
    end

    task automatic wait_done(input string name, input int maxc);
        int n = 0;
        while (!done && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) chk({name, " timeout"}, 64'(done), 64'd1);
    endtask

    typedef struct {
        logic        dw;
        logic [1:0]  mode;
        logic [15:0] seed;
        int          aend;
        logic        fast;
        logic        pre;
        logic [15:0] cmask;
        logic        bad;
        int          cnt;
        int          cnt2;
        int          fb;
        int          nwr;
        int          nrd;
        logic [1:0]  chkm;
        logic [31:0] m0;
        logic [31:0] m3;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int cyc;
        logic snap_rd, snap_wr;
        logic [AW-1:0] snap_addr;
        logic [31:0] snap_wd;

        tbl[0] = '{1'b0, 2'd0, 16'hA55A,  15, 1'b0, 1'b1, 16'h0000, 1'b0, 0, 0, 0,   0,  16, 2'b00, 32'h0, 32'h0};
        tbl[1] = '{1'b1, 2'd1, 16'h0000,   7, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 0, 0,   8,   8, 2'b11, 32'h00010000, 32'h00040003};
        tbl[2] = '{1'b1, 2'd2, 16'h0000, 255, 1'b1, 1'b0, 16'h0000, 1'b0, 0, 0, 0, 256, 256, 2'b11, 32'h5A00B400, 32'h016802D0};
        tbl[3] = '{1'b1, 2'd3, 16'h0000,  15, 1'b0, 1'b0, 16'h0220, 1'b1, 2, 2, 5,  16,  16, 2'b11, 32'hFFFEFFFF, 32'hFFFBFFFC};
        tbl[4] = '{1'b1, 2'd0, 16'h1234,   0, 1'b1, 1'b0, 16'h0000, 1'b0, 0, 0, 0,   1,   1, 2'b01, 32'h12341234, 32'h0};
        tbl[5] = '{1'b1, 2'd1, 16'h0000,  15, 1'b1, 1'b0, 16'h0554, 1'b1, 5, 3, 2,  16,  16, 2'b11, 32'h00010000, 32'h00040003};
        tbl[6] = '{1'b0, 2'd3, 16'h0000,   3, 1'b0, 1'b0, 16'h0000, 1'b1, 4, 3, 0,   0,   4, 2'b00, 32'h0, 32'h0};

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst addr", 64'(addr), 64'd0);
        chk("rst rd_wr", {62'd0, rd, wr}, 64'd0);
        chk("rst wr_data", 64'(wr_data), 64'd0);
        chk("rst busy_done_bad", {61'd0, busy, done, bad}, 64'd0);
        chk("rst err_first", {err_cnt, 16'(first_bad)}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Whole-run vectors
        for (int k = 0; k < 7; k++) begin
            cmask = tbl[k].cmask;
            fast  = tbl[k].fast;
            if (tbl[k].pre) for (int i = 0; i < 256; i++) mem[i] = 32'hA55AA55A;
            @(negedge clk);
            nwr = 0;
            nrd = 0;
            start    = 1'b1;
            do_write = tbl[k].dw;
            mode     = tbl[k].mode;
            seed     = tbl[k].seed;
            addr_end = AW'(tbl[k].aend);
            @(negedge clk);
            start = 1'b0;
            wait_done($sformatf("v%0d", k), 4000);
            chk($sformatf("v%0d done", k), 64'(done), 64'd1);
            chk($sformatf("v%0d busy", k), 64'(busy), 64'd0);
            chk($sformatf("v%0d bad", k), 64'(bad), 64'(tbl[k].bad));
            chk($sformatf("v%0d err_cnt", k), 64'(err_cnt), 64'(tbl[k].cnt));
            chk($sformatf("v%0d err_cnt_sat", k), 64'(err_cnt_s), 64'(tbl[k].cnt2));
            chk($sformatf("v%0d first_bad", k), 64'(first_bad), 64'(tbl[k].fb));
            chk($sformatf("v%0d nwr", k), 64'(nwr), 64'(tbl[k].nwr));
            chk($sformatf("v%0d nrd", k), 64'(nrd), 64'(tbl[k].nrd));
            if (tbl[k].chkm[0]) chk($sformatf("v%0d mem0", k), 64'(mem[0]), 64'(tbl[k].m0));
            if (tbl[k].chkm[1]) chk($sformatf("v%0d mem3", k), 64'(mem[3]), 64'(tbl[k].m3));
        end

        // ack+rdy together: one access per cycle, no stall
        @(negedge clk);
        fast = 1'b1;
        cmask = '0;
        start = 1'b1; do_write = 1'b1; mode = 2'd1; seed = 16'd0; addr_end = AW'(7);
        @(posedge clk); #1;
        chk("fast first req", {62'd0, wr, rd}, 64'd2);
        chk("fast first addr", 64'(addr), 64'd0);
        chk("fast first data", 64'(wr_data), 64'h00010000);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        chk("fast second req", {62'd0, wr, rd}, 64'd2);
        chk("fast second addr", 64'(addr), 64'd1);
        chk("fast second data", 64'(wr_data), 64'h00020001);
        cyc = 1;
        snap_rd = 1'b0; snap_wr = 1'b1; snap_addr = '1; snap_wd = '0;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 8) begin
                snap_rd = rd; snap_wr = wr; snap_addr = addr; snap_wd = wr_data;
            end
        end
        chk("fast phase switch req", {62'd0, snap_wr, snap_rd}, 64'd1);
        chk("fast phase switch addr", 64'(snap_addr), 64'd0);
        chk("fast phase switch data", 64'(snap_wd), 64'h00010000);
        chk("fast total cycles", 64'(cyc), 64'd16);

        // Asynchronous reset in the middle of the write phase
        @(negedge clk);
        fast = 1'b0;
        start = 1'b1; do_write = 1'b1; mode = 2'd2; seed = 16'h00FF; addr_end = AW'(15);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("midw busy before", {62'd0, busy, wr | rd}, 64'd3);
        rst_n = 1'b0;
        #1;
        chk("midw addr", 64'(addr), 64'd0);
        chk("midw rd_wr", {62'd0, rd, wr}, 64'd0);
        chk("midw wr_data", 64'(wr_data), 64'd0);
        chk("midw busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // start during the read phase restarts cleanly
        @(negedge clk);
        cmask = 16'h0002;
        start = 1'b1; do_write = 1'b1; mode = 2'd1; seed = 16'd0; addr_end = AW'(15);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!bad && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("midr bad seen", 64'(bad), 64'd1);
        chk("midr first_bad", 64'(first_bad), 64'd1);
        chk("midr err_cnt", 64'(err_cnt), 64'd1);
        @(negedge clk);
        cmask = '0;
        start = 1'b1; do_write = 1'b1; mode = 2'd1; addr_end = AW'(3);
        @(posedge clk); #1;
        chk("restart addr", 64'(addr), 64'd0);
        chk("restart cleared", {err_cnt, 16'(first_bad), 1'b0, bad}, 64'd0);
        chk("restart req", {61'd0, busy, wr, rd}, 64'd6);
        @(negedge clk);
        start = 1'b0;
        wait_done("restart", 500);
        chk("restart done", 64'(done), 64'd1);
        chk("restart clean", {err_cnt, 15'd0, bad}, 64'd0);
        chk("restart mem3", 64'(mem[3]), 64'h00040003);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
